present_key_schedule: RTL and testbench
=======================================

# present_key_schedule

Iterative PRESENT-80 key schedule sequencer. It loads an 80-bit master key over an 8-bit byte port and holds it in the key state register. It then steps the state through the 31 PRESENT key-update rounds, one round per consumer acknowledge. Each of the 32 round keys K1..K32 is presented to the downstream round datapath with a valid/next handshake.

## Interface
Parameters:
- None. Key width 80, round-key width 64 and round count 32 are fixed by PRESENT-80.

Ports:
- Clk_ik  in  1  system clock; all state on rising edge
- Reset_iran  in  1  asynchronous active-low reset
- KeyByte_ib  in  8  master key byte, MSB byte first
- KeyByteValid_i  in  1  shifts KeyByte_ib into key state (IDLE only)
- Start_i  in  1  begin schedule generation (IDLE only)
- Next_i  in  1  consumer acknowledge of current round key
- RoundKey_ob  out  64  current round key, key state [79:16]
- RoundCount_ob  out  5  index of current round key (1..31); 0 when idle, and 0 (wrapped) for K32
- RoundKeyValid_o  out  1  RoundKey_ob/RoundCount_ob valid
- Busy_o  out  1  high in RUN
- Done_o  out  1  one-cycle pulse after K32 acknowledged

## Operation
- Key state K[79:0] and round counter R[5:0] are internal. RoundCount_ob = R[4:0].
- States: IDLE, RUN.
- IDLE behaviour:
  - KeyByteValid_i: K <= {K[71:0], KeyByte_ib}. Ten bytes load a full key, first byte into K[79:72]. Fewer bytes perform a partial shift, with no error.
  - Start_i with KeyByteValid_i low: R <= 1, go to RUN.
  - Start_i and KeyByteValid_i in the same cycle: the byte shifts and Start_i is ignored.
- RUN behaviour:
  - RoundKeyValid_o = 1 and Busy_o = 1.
  - Next_i with R < 32: K <= update(K, R[4:0]) and R <= R+1.
  - Next_i with R == 32: go to IDLE, pulse Done_o, R <= 0.
- update(K, c), per the PRESENT-80 specification:
  - rotate K left by 61;
  - replace bits [79:76] with S(bits [79:76]) using the PRESENT S-box (C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2);
  - XOR bits [19:15] with the 5-bit c.
- All 5 counter bits are applied; there is no truncation.
- Ignored inputs:
  - Start_i and KeyByteValid_i in RUN are ignored; the key cannot change mid-schedule.
  - Next_i in IDLE is ignored.
- Outputs are registered or decoded from state only, with no combinational path from inputs to outputs.

## Timing
- Reset values: K = 0, R = 0, state IDLE. RoundKey_ob = 0, RoundCount_ob = 0, RoundKeyValid_o = 0, Busy_o = 0, Done_o = 0.
- Start_i sampled at edge n: from edge n, RoundKeyValid_o = 1, RoundCount_ob = 1 and RoundKey_ob = K1.
- Next_i sampled at edge n while valid: from edge n, the next key Ki+1 and count are shown. Throughput is one round key per cycle if Next_i is held high.
- A holding Next_i low stalls indefinitely with outputs stable.
- Minimum schedule length: 32 cycles from Start to the last Next; Done_o is high in the cycle after the final Next edge.
- Reset asserted mid-RUN aborts immediately: all state returns to reset values and Done_o does not pulse.

## Configuration
- PRESENT_KEY_RESTORE_EN defined:
  - adds an 80-bit master-key shadow register, written in parallel with K on every KeyByteValid_i shift;
  - on the K32 acknowledge, K <= shadow, so a repeated Start_i reproduces K1..K32 without reloading.
- PRESENT_KEY_RESTORE_EN undefined:
  - no shadow register;
  - after Done, K retains the last updated state (the state that produced K32);
  - a new Start_i without reload runs the schedule from that state, which is defined behaviour but not the original key.

## Test plan
- Reset, then load ten 0x00 bytes and Start: K1 = 0x0000000000000000 with count 1. Next gives K2 = 0xC000000000000000 with count 2.
- Load 0xFF x10, Start, hold Next_i high: 32 consecutive valid keys matching the golden software model. Done_o is high exactly once, one cycle after the 32nd acknowledge. Busy_o falls in the same cycle.
- Stall: Next_i low for 5 cycles at count 7: RoundKey_ob and count stay unchanged. Then Next_i high: count 8.
- Ignored inputs:
  - KeyByteValid_i and Start_i pulsed during RUN: schedule unaffected.
  - Start_i together with KeyByteValid_i in IDLE: byte shifted, state stays IDLE.
- Assert Reset_iran at count 15: all outputs return to 0 asynchronously and Done_o never pulses. A subsequent Start gives K1 = 0.
- Second Start after completion, no reload:
  - with PRESENT_KEY_RESTORE_EN: K1 equals the original K1;
  - without it: K1 equals the top 64 bits of the final update state.

Source files
------------

// File: rtl/present_key_schedule.sv
// Iterative PRESENT-80 key schedule: byte-wise master key load, then one key-update round per acknowledge.
// Optional build macro PRESENT_KEY_RESTORE_EN adds a master-key shadow restored after K32 is acknowledged.
module present_key_schedule (
  input  logic        Clk_ik,
  input  logic        Reset_iran,
  input  logic [7:0]  KeyByte_ib,
  input  logic        KeyByteValid_i,
  input  logic        Start_i,
  input  logic        Next_i,
  output logic [63:0] RoundKey_ob,
  output logic [4:0]  RoundCount_ob,
  output logic        RoundKeyValid_o,
  output logic        Busy_o,
  output logic        Done_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [79:0] key;
  logic [5:0]  round;
  logic        done;
`ifdef PRESENT_KEY_RESTORE_EN
  logic [79:0] shadow;
`endif

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Rotate left by 61 is the same as rotate right by 19.
  function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sbox(r[79:76]);
    r[19:15] = r[19:15] ^ c;
    return r;
  endfunction

  always_ff @(posedge Clk_ik or negedge Reset_iran) begin
    if (!Reset_iran) begin
      state <= IDLE;
      key   <= '0;
      round <= '0;
      done  <= 1'b0;
`ifdef PRESENT_KEY_RESTORE_EN
      shadow <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        // A byte shift takes priority over Start in the same cycle.
        if (KeyByteValid_i) begin
          key <= {key[71:0], KeyByte_ib};
`ifdef PRESENT_KEY_RESTORE_EN
          shadow <= {shadow[71:0], KeyByte_ib};
`endif
        end else if (Start_i) begin
          round <= 6'd1;
          state <= RUN;
        end
      end else if (Next_i) begin
        if (round == 6'd32) begin
          state <= IDLE;
          done  <= 1'b1;
          round <= '0;
`ifdef PRESENT_KEY_RESTORE_EN
          key   <= shadow;
`endif
        end else begin
          key   <= key_update(key, round[4:0]);
          round <= round + 6'd1;
        end
      end
    end
  end

  assign RoundKey_ob     = key[79:16];
  assign RoundCount_ob   = round[4:0];
  assign RoundKeyValid_o = (state == RUN);
  assign Busy_o          = (state == RUN);
  assign Done_o          = done;

endmodule

// File: tb/tb_present_key_schedule.sv
// Randomized directed bench for present_key_schedule against an arithmetic PRESENT-80 key schedule model.
// Expectations for a second Start without reload follow PRESENT_KEY_RESTORE_EN.
module tb_present_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  key_byte = '0;
  logic        key_byte_valid = 1'b0;
  logic        start = 1'b0;
  logic        next = 1'b0;
  logic [63:0] round_key;
  logic [4:0]  round_count;
  logic        round_key_valid;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0]  sbox_tbl [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [63:0] rk [1:32];
  logic [79:0] fin_state;
  logic [79:0] model_k;
  logic [79:0] rand_key;
  logic [79:0] again_key;
  logic [7:0]  b;

  present_key_schedule dut (
    .Clk_ik          (clk),
    .Reset_iran      (rst_n),
    .KeyByte_ib      (key_byte),
    .KeyByteValid_i  (key_byte_valid),
    .Start_i         (start),
    .Next_i          (next),
    .RoundKey_ob     (round_key),
    .RoundCount_ob   (round_count),
    .RoundKeyValid_o (round_key_valid),
    .Busy_o          (busy),
    .Done_o          (done)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] model_update(input logic [79:0] k, input int c);
    logic [79:0] r;
    logic [79:0] cv;
    r = (k << 61) | (k >> 19);
    r[79:76] = sbox_tbl[r[79:76]];
    cv = 80'(c);
    return r ^ (cv << 15);
  endfunction

  // Fill rk[1..32] from a master key; fin_state is the state that yields K32.
  task automatic build_model(input logic [79:0] k);
    logic [79:0] st;
    st = k;
    for (int i = 1; i <= 32; i++) begin
      rk[i] = st[79:16];
      if (i < 32) st = model_update(st, i);
    end
    fin_state = st;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [79:0] k);
    for (int i = 9; i >= 0; i--) begin
      key_byte = k[i*8 +: 8];
      key_byte_valid = 1'b1;
      tick();
    end
    key_byte_valid = 1'b0;
  endtask

  // Start and hold Next high through all 32 keys, checking every key and the Done pulse.
  task automatic run_full(input logic [79:0] k, input string tag);
    build_model(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    next = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      check_output({tag, "_key"}, round_key, rk[i]);
      check_output({tag, "_count"}, 64'(round_count), 64'(i % 32));
      check_output({tag, "_valid"}, 64'(round_key_valid), 64'd1);
      check_output({tag, "_busy"}, 64'(busy), 64'd1);
      check_output({tag, "_done_early"}, 64'(done), 64'd0);
      tick();
    end
    next = 1'b0;
    check_output({tag, "_done"}, 64'(done), 64'd1);
    check_output({tag, "_busy_end"}, 64'(busy), 64'd0);
    check_output({tag, "_valid_end"}, 64'(round_key_valid), 64'd0);
    check_output({tag, "_count_end"}, 64'(round_count), 64'd0);
    tick();
    check_output({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check_output("rst_key", round_key, 64'd0);
    check_output("rst_count", 64'(round_count), 64'd0);
    check_output("rst_valid", 64'(round_key_valid), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // All-zero key: first two keys against known constants
    load_key(80'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("zero_k1", round_key, 64'h0000000000000000);
    check_output("zero_c1", 64'(round_count), 64'd1);
    next = 1'b1;
    tick();
    next = 1'b0;
    check_output("zero_k2", round_key, 64'hC000000000000000);
    check_output("zero_c2", 64'(round_count), 64'd2);
    next = 1'b1;
    for (int i = 0; i < 31; i++) tick();
    next = 1'b0;
    check_output("zero_done", 64'(done), 64'd1);
    tick();

    // All-ones key full run, then a second Start without reload
    load_key({80{1'b1}});
    run_full({80{1'b1}}, "ff");
`ifdef PRESENT_KEY_RESTORE_EN
    again_key = {80{1'b1}};
`else
    again_key = fin_state;
`endif
    run_full(again_key, "again");

    // Random key with a stall at count 7 and ignored inputs during RUN
    rand_key = {$urandom(), $urandom(), 16'($urandom())};
    load_key(rand_key);
    build_model(rand_key);
    start = 1'b1;
    tick();
    start = 1'b0;
    next = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    next = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_output("stall_key", round_key, rk[7]);
      check_output("stall_count", 64'(round_count), 64'd7);
      key_byte = 8'($urandom());
      key_byte_valid = (i == 1);
      start = (i == 2);
      tick();
    end
    key_byte_valid = 1'b0;
    start = 1'b0;
    next = 1'b1;
    tick();
    next = 1'b0;
    check_output("resume_key", round_key, rk[8]);
    check_output("resume_count", 64'(round_count), 64'd8);
    next = 1'b1;
    for (int i = 9; i <= 32; i++) begin
      tick();
      check_output("run_ignored_key", round_key, rk[i]);
    end
    tick();
    next = 1'b0;
    check_output("rand_done", 64'(done), 64'd1);
`ifdef PRESENT_KEY_RESTORE_EN
    model_k = rand_key;
`else
    model_k = fin_state;
`endif
    tick();

    // Start together with a byte in IDLE: byte shifts, no RUN
    b = 8'($urandom());
    key_byte = b;
    key_byte_valid = 1'b1;
    start = 1'b1;
    tick();
    key_byte_valid = 1'b0;
    start = 1'b0;
    model_k = {model_k[71:0], b};
    check_output("idle_shift_key", round_key, model_k[79:16]);
    check_output("idle_shift_busy", 64'(busy), 64'd0);
    check_output("idle_shift_valid", 64'(round_key_valid), 64'd0);
    tick();
    check_output("idle_shift_busy2", 64'(busy), 64'd0);

    // Reset asserted mid-RUN at count 15
    rand_key = {$urandom(), $urandom(), 16'($urandom())};
    load_key(rand_key);
    build_model(rand_key);
    start = 1'b1;
    tick();
    start = 1'b0;
    next = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    next = 1'b0;
    check_output("pre_abort_count", 64'(round_count), 64'd15);
    check_output("pre_abort_key", round_key, rk[15]);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("abort_key", round_key, 64'd0);
    check_output("abort_count", 64'(round_count), 64'd0);
    check_output("abort_valid", 64'(round_key_valid), 64'd0);
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_done", 64'(done), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_output("abort_done_hold", 64'(done), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_output("post_abort_done", 64'(done), 64'd0);
    run_full(80'd0, "post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
